axi_rd_responder: RTL and testbench
===================================

Name: axi_rd_responder

Overview:
- AXI4 read-channel responder (memory side) that terminates the AR/R master port driven by the prefetcher controller.
- Accepts read requests into an in-order queue and returns R bursts after a programmable access latency.
- Data is deterministic and address-derived, so the block serves both as a synthesizable memory stub and as the bench target for prefetcher closed-loop tests.

Parameters:
ADDR_BITS, 64, address width
LOG_BLOCK_DATA_BYTES, 6, log2 bytes per data beat; BLOCK_DATA_SIZE_BITS = (1<<LOG_BLOCK_DATA_BYTES)*8, which must be a multiple of ADDR_BITS
BURST_LEN_WIDTH, 8, AXI len field width (beats = len+1)
TID_WIDTH, 8, transaction ID width
LOG_QUEUE_SIZE, 2, log2 request queue depth
LATENCY_WIDTH, 8, width of latency config

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
en  in  1  enables acceptance and burst start
s_ar_valid  in  1  request valid
s_ar_ready  out  1  request ready
s_ar_addr  in  ADDR_BITS  burst start address
s_ar_len  in  BURST_LEN_WIDTH  beats minus one
s_ar_id  in  TID_WIDTH  transaction ID
s_r_valid  out  1  data valid
s_r_ready  in  1  data ready
s_r_last  out  1  final beat of burst
s_r_data  out  BLOCK_DATA_SIZE_BITS  beat data
s_r_id  out  TID_WIDTH  ID of the burst being returned
cfg_latency  in  LATENCY_WIDTH  wait cycles before the first beat
outstandingCnt  out  LOG_QUEUE_SIZE+1  queued requests plus the request in service
busy  out  1  outstandingCnt != 0

Behaviour:
- Reset (async): queue empty, FSM in IDLE, s_ar_ready=0, s_r_valid=0, s_r_last=0, s_r_data=0, s_r_id=0, outstandingCnt=0, busy=0.
- s_ar_ready = en & ~queueFull. It is combinational from registered state and does not depend on s_ar_valid.
- AR handshake (valid & ready) pushes {addr, len, id} into the FIFO. Simultaneous push and pop leaves the queue count unchanged.
- Maximum outstanding = 2^LOG_QUEUE_SIZE + 1 (full queue plus one in service).
- FSM states: IDLE, WAIT, BURST.
  - IDLE: if queue non-empty and en=1, pop the head into the service registers and sample cfg_latency. If latency=0, go to BURST; otherwise go to WAIT with the counter loaded to latency-1.
  - WAIT: decrement the counter each cycle; at 0, go to BURST. WAIT lasts exactly cfg_latency cycles. cfg_latency changes after sampling have no effect.
  - BURST: s_r_valid=1 and beat index k starts at 0.
    - On each s_r_valid & s_r_ready: k increments and the next beat is presented the following cycle.
    - s_r_last=1 only when k == len.
    - The handshake of the last beat returns the FSM to IDLE.
- Timing, empty queue and IDLE: AR handshake in cycle T gives the first s_r_valid in cycle T+2+L.
- Back-to-back bursts: a minimum of 1+L cycles between the last beat of one burst and the first beat of the next.
- Beat address = (addr + k*2^LOG_BLOCK_DATA_BYTES) mod 2^ADDR_BITS, so wrap-around is silent.
- s_r_data = beat address replicated BLOCK_DATA_SIZE_BITS/ADDR_BITS times.
- s_r_id = the stored ID of the burst in service.
- While s_r_valid=1 and s_r_ready=0, s_r_data, s_r_last and s_r_id are held stable and s_r_valid is never withdrawn.
- en=0 does not abort work in progress:
  - It blocks new AR acceptance and the IDLE->WAIT/BURST transition.
  - A burst already in WAIT or BURST runs to completion.
- outstandingCnt: +1 on push, -1 on the last-beat handshake. Push and last-beat handshake in the same cycle leave it unchanged.
- Reset asserted mid-burst: s_r_valid drops immediately and all queued requests are discarded.
- Bursts return strictly in AR order regardless of ID; there is no interleaving.

Test Plan:
- L=3, AR {addr=0x1000, len=0, id=5} at cycle T, s_r_ready=1 -> s_r_valid only in T+5; data = 8 copies of 0x1000; last=1; id=5; outstandingCnt 1 during T+1..T+5, 0 at T+6.
- L=0, AR {0x2000, len=3, id=2}, ready=1 -> 4 consecutive beats with data 0x2000, 0x2040, 0x2080, 0x20C0; last only on the 4th; first beat at T+2.
- Same burst with s_r_ready toggling 1,0,0,1,0,1... -> each beat stable while stalled; exactly 4 handshakes; no beat skipped or repeated.
- s_r_ready=0, s_ar_valid held with 6 distinct requests -> 5 accepted; s_ar_ready=0 from then on; outstandingCnt=5; releasing ready returns all 5 bursts in order and s_ar_ready reasserts after the first burst completes.
- AR {0xFFFFFFFFFFFFFFC0, len=1}, L=1 -> beat 0 data = 0xFFFFFFFFFFFFFFC0 copies, beat 1 data = 0x0 copies, last on beat 1.
- Assert reset during beat 2 of a len=7 burst with 2 more requests queued -> s_r_valid=0 during reset; after deassert, outstandingCnt=0 and there is no further R traffic. Separately, en=0 mid-burst -> burst completes, queued request not started until en=1.

Source files
------------

// File: rtl/axi_rd_responder.sv
// axi_rd_responder: in-order AXI4 read responder returning address-derived
// data bursts after a programmable access latency.
module axi_rd_responder #(
    parameter int ADDR_BITS            = 64,
    parameter int LOG_BLOCK_DATA_BYTES = 6,
    parameter int BURST_LEN_WIDTH      = 8,
    parameter int TID_WIDTH            = 8,
    parameter int LOG_QUEUE_SIZE       = 2,
    parameter int LATENCY_WIDTH        = 8,
    localparam int BLOCK_DATA_SIZE_BITS = (1 << LOG_BLOCK_DATA_BYTES) * 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            en,
    input  logic                            s_ar_valid,
    output logic                            s_ar_ready,
    input  logic [ADDR_BITS-1:0]            s_ar_addr,
    input  logic [BURST_LEN_WIDTH-1:0]      s_ar_len,
    input  logic [TID_WIDTH-1:0]            s_ar_id,
    output logic                            s_r_valid,
    input  logic                            s_r_ready,
    output logic                            s_r_last,
    output logic [BLOCK_DATA_SIZE_BITS-1:0] s_r_data,
    output logic [TID_WIDTH-1:0]            s_r_id,
    input  logic [LATENCY_WIDTH-1:0]        cfg_latency,
    output logic [LOG_QUEUE_SIZE:0]         outstandingCnt,
    output logic                            busy
);
    localparam int QD  = 1 << LOG_QUEUE_SIZE;
    localparam int CW  = LOG_QUEUE_SIZE + 1;
    localparam int REP = BLOCK_DATA_SIZE_BITS / ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] STEP = ADDR_BITS'(1) << LOG_BLOCK_DATA_BYTES;

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

    logic [ADDR_BITS-1:0]       r_q_addr [QD];
    logic [BURST_LEN_WIDTH-1:0] r_q_len  [QD];
    logic [TID_WIDTH-1:0]       r_q_id   [QD];
    logic [LOG_QUEUE_SIZE-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]              r_count, r_out;
    state_t                     r_state, w_next;
    logic [ADDR_BITS-1:0]       r_baddr;
    logic [BURST_LEN_WIDTH-1:0] r_len, r_k;
    logic [TID_WIDTH-1:0]       r_id;
    logic [LATENCY_WIDTH-1:0]   r_lat;
    logic                       w_push, w_pop, w_beat, w_done;

    // count MSB is set only when the queue holds exactly QD entries
    assign s_ar_ready     = en & ~r_count[LOG_QUEUE_SIZE] & ~reset;
    assign w_push         = s_ar_valid & s_ar_ready;
    assign w_pop          = (r_state == IDLE) & en & (r_count != '0);
    assign w_beat         = (r_state == BURST) & s_r_ready;
    assign w_done         = w_beat & (r_k == r_len);
    assign s_r_valid      = r_state == BURST;
    assign s_r_last       = s_r_valid & (r_k == r_len);
    assign s_r_data       = {REP{r_baddr}};
    assign s_r_id         = r_id;
    assign outstandingCnt = r_out;
    assign busy           = r_out != '0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_addr[r_wr_ptr] <= s_ar_addr;
            r_q_len[r_wr_ptr]  <= s_ar_len;
            r_q_id[r_wr_ptr]   <= s_ar_id;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_out    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + LOG_QUEUE_SIZE'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + LOG_QUEUE_SIZE'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            r_out   <= r_out + CW'(w_push) - CW'(w_done);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_pop) w_next = (cfg_latency == '0) ? BURST : WAIT;
            WAIT:    if (r_lat == '0) w_next = BURST;
            BURST:   if (w_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // latency is captured at pop so later cfg_latency changes cannot stretch a wait
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_baddr <= '0;
            r_len   <= '0;
            r_k     <= '0;
            r_id    <= '0;
            r_lat   <= '0;
        end else if (w_pop) begin
            r_baddr <= r_q_addr[r_rd_ptr];
            r_len   <= r_q_len[r_rd_ptr];
            r_id    <= r_q_id[r_rd_ptr];
            r_k     <= '0;
            r_lat   <= cfg_latency - LATENCY_WIDTH'(1);
        end else begin
            if (r_state == WAIT) r_lat <= r_lat - LATENCY_WIDTH'(1);
            if (w_beat) begin
                r_baddr <= r_baddr + STEP;
                r_k     <= r_k + BURST_LEN_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_axi_rd_responder.sv
// tb_axi_rd_responder: directed and random stimulus checked each cycle against
// a transaction-level model of request queueing, latency and beat contents.
module tb_axi_rd_responder;
    logic         clk = 0;
    logic         reset, en, s_ar_valid, s_ar_ready, s_r_valid, s_r_ready, s_r_last, busy;
    logic [63:0]  s_ar_addr;
    logic [7:0]   s_ar_len, s_ar_id, s_r_id, cfg_latency;
    logic [511:0] s_r_data;
    logic [2:0]   outstandingCnt;

    axi_rd_responder dut (
        .clk(clk), .reset(reset), .en(en),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
        .s_ar_len(s_ar_len), .s_ar_id(s_ar_id),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_last(s_r_last),
        .s_r_data(s_r_data), .s_r_id(s_r_id), .cfg_latency(cfg_latency),
        .outstandingCnt(outstandingCnt), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int          len;
        logic [7:0]  id;
        int          acc;
    } req_t;

    // model: requests in AR order; head is popped one cycle after both its
    // acceptance and the previous burst's end, gated by en; beats start lat+1 later
    req_t q[$];
    int   cyc = 0, prev_last = -1000, pop_cyc = 0, lat = 0, k = 0;
    bit   popped = 0, acc;
    int   n_vec = 0, n_bad = 0;

    function automatic bit mvalid();
        return q.size() > 0 && popped && cyc >= pop_cyc + 1 + lat;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic cycle(input bit arv, input logic [63:0] a, input int len, input logic [7:0] id,
                         input bit rr, input bit e, input int l, output bit accepted);
        bit          v, rdy;
        int          insv;
        logic [63:0] ba;
        s_ar_valid = arv; s_ar_addr = a; s_ar_len = len[7:0]; s_ar_id = id;
        s_r_ready = rr; en = e; cfg_latency = l[7:0];
        @(negedge clk);
        v    = mvalid();
        insv = (q.size() > 0 && popped && cyc > pop_cyc) ? 1 : 0;
        rdy  = e && (q.size() - insv) < 4;
        chk("ar_ready", s_ar_ready, rdy);
        chk("outstanding", outstandingCnt, q.size());
        chk("busy", busy, q.size() != 0);
        chk("r_valid", s_r_valid, v);
        if (v) begin
            ba = q[0].addr + 64'(k) * 64'd64;
            chk("r_data", s_r_data, {8{ba}});
            chk("r_last", s_r_last, k == q[0].len);
            chk("r_id", s_r_id, q[0].id);
        end
        if (v && rr) begin
            k++;
            if (k > q[0].len) begin
                void'(q.pop_front());
                prev_last = cyc; popped = 0; k = 0;
            end
        end
        if (!popped && q.size() > 0 && e && cyc >= q[0].acc + 1 && cyc >= prev_last + 1) begin
            popped = 1; pop_cyc = cyc; lat = l;
        end
        accepted = arv && rdy;
        if (accepted) q.push_back('{a, len, id, cyc});
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic idle(input bit rr, input bit e, input int l);
        bit d;
        cycle(0, 64'h0, 0, 8'h0, rr, e, l, d);
    endtask

    task automatic do_reset(input int n);
        reset = 1; s_ar_valid = 0; s_r_ready = 1; en = 1;
        @(negedge clk);
        chk("rst_r_valid", s_r_valid, 0);
        chk("rst_r_last", s_r_last, 0);
        chk("rst_r_data", s_r_data, 0);
        chk("rst_r_id", s_r_id, 0);
        chk("rst_ar_ready", s_ar_ready, 0);
        chk("rst_outstanding", outstandingCnt, 0);
        chk("rst_busy", busy, 0);
        repeat (n) @(posedge clk);
        #1;
        reset = 0;
        q.delete(); popped = 0; k = 0; prev_last = -1000;
        cyc += n;
    endtask

    task automatic rand_cycle(input bit rand_lat);
        cycle($urandom_range(0, 2) != 0, {$urandom, $urandom}, $urandom_range(0, 3), 8'($urandom),
              $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
              rand_lat ? $urandom_range(0, 3) : 2, acc);
    endtask

    initial begin
        int idx;
        reset = 0; en = 0; s_ar_valid = 0; s_r_ready = 0; s_ar_addr = 0;
        s_ar_len = 0; s_ar_id = 0; cfg_latency = 0;
        @(posedge clk); #1;
        do_reset(2);

        // single beat, latency 3
        cycle(1, 64'h1000, 0, 8'd5, 1, 1, 3, acc);
        repeat (8) idle(1, 1, 3);
        // four-beat burst, latency 0
        cycle(1, 64'h2000, 3, 8'd2, 1, 1, 0, acc);
        repeat (8) idle(1, 1, 0);
        // same burst under back-pressure
        cycle(1, 64'h2000, 3, 8'd2, 1, 1, 0, acc);
        for (int i = 0; i < 16; i++) idle((i % 3) != 1, 1, 0);

        // fill queue plus service slot with r_ready low, then drain
        idx = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(idx < 6, 64'h3000 + 64'(idx) * 64'h1000, idx % 3, 8'(idx), 0, 1, 1, acc);
            if (acc) idx++;
        end
        for (int i = 0; i < 60 && idx < 6; i++) begin
            cycle(1, 64'h3000 + 64'(idx) * 64'h1000, idx % 3, 8'(idx), 1, 1, 1, acc);
            if (acc) idx++;
        end
        chk("sixth_accepted", idx, 6);
        repeat (20) idle(1, 1, 1);

        // address wrap-around
        cycle(1, 64'hFFFF_FFFF_FFFF_FFC0, 1, 8'd7, 1, 1, 1, acc);
        repeat (6) idle(1, 1, 1);

        for (int i = 0; i < 400; i++) rand_cycle(0);
        for (int i = 0; i < 200 && q.size() != 0; i++) idle(1, 1, 2);
        chk("drain1", q.size(), 0);

        // reset in the middle of beat 2 with two requests queued
        cycle(1, 64'h8000, 7, 8'd1, 1, 1, 0, acc);
        cycle(1, 64'h9000, 0, 8'd2, 1, 1, 0, acc);
        cycle(1, 64'hA000, 0, 8'd3, 1, 1, 0, acc);
        for (int i = 0; i < 20 && !(mvalid() && k == 2); i++) idle(1, 1, 0);
        chk("reach_beat2", mvalid() && k == 2, 1);
        do_reset(2);
        repeat (10) idle(1, 1, 0);

        // en low mid-burst: burst completes, queued one waits
        cycle(1, 64'hB000, 3, 8'd4, 1, 1, 0, acc);
        cycle(1, 64'hC000, 0, 8'd5, 1, 1, 0, acc);
        idle(1, 1, 0);
        repeat (12) idle(1, 0, 0);
        repeat (6) idle(1, 1, 0);

        for (int i = 0; i < 600; i++) rand_cycle(1);
        for (int i = 0; i < 200 && q.size() != 0; i++) idle(1, 1, 1);
        chk("drain2", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
